// File: rtl/fetch_pkg.sv
// Shared constants and types for the RV32 instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  // One decoded-side buffer entry: the instruction word and the address it came from.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a flush input and a combinational head.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  // A pop needs data; a push needs room, which a same-cycle pop provides when full.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy update; flush empties the FIFO and ignores that cycle's traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// RV32 instruction fetch stage: owns the fetch PC, issues in-order memory
// reads under a credit limit, pairs responses with their addresses and
// buffers them for decode. Redirects flush everything and mark responses
// already in flight for discard.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [WIDTH-1:0]   imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [WIDTH-1:0]   if_pc,
  output logic [WIDTH-1:0]   fetch_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  // Drops can pile up across back-to-back redirects while earlier discards
  // are still in the memory pipeline, so the counter gets extra headroom.
  localparam int DW = CW + 2;
  localparam int EW = WIDTH + INSTR_W;

  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    buf_count;
  logic [DW-1:0]    drop_cnt;
  logic [SW-1:0]    in_use;
  logic             req_fire;
  logic             rsp_drop;
  logic             rsp_keep;
  logic             dec_pop;
  logic [WIDTH-1:0] head_addr;
  logic [EW-1:0]    buf_head;
  logic             unused_low_bits;

  // The target is word aligned by construction; the low bits are ignored.
  assign unused_low_bits = &{1'b0, redirect_pc[1:0]};

  // Credit check: live in-flight requests plus buffered words never exceed DEPTH.
  assign in_use         = SW'(outstanding) + SW'(buf_count);
  assign imem_req_valid = !redirect_valid && (in_use < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses owed to a flushed PC stream are swallowed before any live one.
  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign if_valid = (buf_count != '0) && !redirect_valid;
  assign dec_pop  = if_valid && if_ready;
  assign if_pc    = buf_head[EW-1 -: WIDTH];
  assign if_instr = buf_head[INSTR_W-1:0];

  // Addresses of live requests; its occupancy is the outstanding count.
  fetch_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_inflight (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head      (head_addr),
    .count     (outstanding)
  );

  // {pc, instr} pairs waiting for decode.
  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_outbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({head_addr, imem_rsp_data}),
    .pop       (dec_pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  // Fetch PC: redirect target wins, otherwise step past each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + WIDTH'(PC_STEP);
    end
  end

  // Discard counter: a redirect turns every live request into a pending drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= drop_cnt + DW'(outstanding) + DW'(req_fire) - DW'(imem_rsp_valid);
    end else if (rsp_drop) begin
      drop_cnt <= drop_cnt - DW'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table-driven cycle vectors plus
// hand-written sequences for backpressure, flushes and mid-stream reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] fetch_pc;

  always #5 clk = ~clk;

  instr_fetch #(.WIDTH(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_pc       (fetch_pc)
  );

  typedef struct {
    logic        rst;    // reset before this row
    logic        redir;
    logic [31:0] rpc;
    logic        e_rv;   // expected imem_req_valid
    logic [31:0] e_addr; // expected imem_req_addr and fetch_pc
    logic        e_iv;   // expected if_valid
    logic [31:0] e_pc;   // expected if_pc when if_valid
  } vec_t;

  vec_t        tab [19];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  logic [31:0] pend_addr [$];
  int          pend_due [$];
  logic [31:0] del_pc [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0bad_f00d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model drives this cycle's response, then lets logic settle.
  task automatic begin_cycle();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
    #1;
  endtask

  // Record handshakes seen before the edge, then advance to the next cycle.
  task automatic end_cycle();
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + mem_lat);
    end
    if (if_valid && if_ready) begin
      $display("cycle %0d deliver pc=%h instr=%h", cyc, if_pc, if_instr);
      del_pc.push_back(if_pc);
      chk("instr", if_instr, mem_word(if_pc));
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend_addr.delete();
    pend_due.delete();
    del_pc.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  initial begin
    int nreq;
    int budget;

    // Stall-free fetch with 1-cycle memory (credit limit throttles every third slot).
    tab[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0};
    tab[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b0, 32'h0};
    tab[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000};
    tab[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
    tab[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b0, 32'h0};
    tab[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};
    tab[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};
    // Redirect in the same cycle as a response and a would-be decode pop.
    tab[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0};
    tab[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b0, 32'h0};
    tab[9]  = '{1'b0, 1'b1, 32'h200,      1'b0, 32'h0000_0008, 1'b0, 32'h0};
    tab[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0200, 1'b0, 32'h0};
    tab[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0204, 1'b0, 32'h0};
    tab[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0208, 1'b1, 32'h0000_0200};
    // Misaligned target, then a target at the top of the address space.
    tab[13] = '{1'b1, 1'b1, 32'h103,      1'b0, 32'h0000_0000, 1'b0, 32'h0};
    tab[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b0, 32'h0};
    tab[15] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0104, 1'b0, 32'h0};
    tab[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
    tab[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0};
    tab[18] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC};

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b1;
    #1;
    chk("reset fetch_pc", fetch_pc, 32'h0);
    chk("reset if_valid", {31'b0, if_valid}, 32'h0);

    // ---------------- table vectors ----------------
    mem_lat = 1;
    for (int i = 0; i < 19; i++) begin
      if (tab[i].rst) do_reset();
      if_ready       = 1'b1;
      redirect_valid = tab[i].redir;
      redirect_pc    = tab[i].rpc;
      begin_cycle();
      chk($sformatf("row%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, tab[i].e_rv});
      chk($sformatf("row%0d req_addr", i), imem_req_addr, tab[i].e_addr);
      chk($sformatf("row%0d fetch_pc", i), fetch_pc, tab[i].e_addr);
      chk($sformatf("row%0d if_valid", i), {31'b0, if_valid}, {31'b0, tab[i].e_iv});
      if (tab[i].e_iv) chk($sformatf("row%0d if_pc", i), if_pc, tab[i].e_pc);
      end_cycle();
      redirect_valid = 1'b0;
    end

    // ---------------- decode backpressure ----------------
    mem_lat = 1;
    do_reset();
    if_ready = 1'b0;
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      begin_cycle();
      if (imem_req_valid && imem_req_ready) nreq++;
      end_cycle();
    end
    begin_cycle();
    chk("bp req count", nreq, 2);
    chk("bp req_valid held low", {31'b0, imem_req_valid}, 32'h0);
    chk("bp if_valid", {31'b0, if_valid}, 32'h1);
    end_cycle();
    if_ready = 1'b1;
    run(6);
    chk("bp delivered >=2", {31'b0, del_pc.size() >= 2}, 32'h1);
    if (del_pc.size() >= 2) begin
      chk("bp first pc", del_pc[0], 32'h0);
      chk("bp second pc", del_pc[1], 32'h4);
    end

    // ---------------- redirect with two in flight, 3-cycle memory ----------------
    mem_lat = 3;
    do_reset();
    if_ready = 1'b1;
    run(7);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    begin_cycle();
    chk("rd outstanding", {28'b0, dut.outstanding}, 32'h2);
    chk("rd req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rd if_valid", {31'b0, if_valid}, 32'h0);
    end_cycle();
    redirect_valid = 1'b0;
    del_pc.delete();
    begin_cycle();
    chk("rd drop_cnt", {28'b0, dut.drop_cnt}, 32'h2);
    chk("rd target req", imem_req_addr, 32'h100);
    end_cycle();
    budget = 0;
    while (del_pc.size() == 0 && budget < 20) begin
      begin_cycle();
      end_cycle();
      budget++;
    end
    chk("rd delivered in time", {31'b0, del_pc.size() > 0}, 32'h1);
    if (del_pc.size() > 0) chk("rd first pc after redirect", del_pc[0], 32'h100);
    chk("rd drop_cnt drained", {28'b0, dut.drop_cnt}, 32'h0);

    // ---------------- reset mid-stream with two outstanding ----------------
    mem_lat = 3;
    do_reset();
    run(2);
    begin_cycle();
    chk("mr pre fetch_pc", fetch_pc, 32'h8);
    chk("mr pre outstanding", {28'b0, dut.outstanding}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mr fetch_pc async", fetch_pc, 32'h0);
    chk("mr outstanding async", {28'b0, dut.outstanding}, 32'h0);
    chk("mr if_valid", {31'b0, if_valid}, 32'h0);

    // Reset while a word is being presented to decode.
    mem_lat = 2;
    do_reset();
    run(3);
    begin_cycle();
    chk("mr2 pre if_valid", {31'b0, if_valid}, 32'h1);
    chk("mr2 pre if_pc", if_pc, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mr2 if_valid async", {31'b0, if_valid}, 32'h0);
    pend_addr.delete();
    pend_due.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    begin_cycle();
    chk("mr2 restart req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("mr2 restart addr", imem_req_addr, 32'h0);
    end_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
